// File: rtl/data_wrap.sv
// Y86-64 memory stage: byte-addressed little-endian data memory with icode-driven
// address/data selection, combinational read data and processor status generation.
module data_wrap #(
  parameter int MEM_BYTES  = 65536,
  parameter int WORD_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic [63:0] valM,
  output logic [1:0]  stat
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'b00;
  localparam logic [1:0] S_HLT = 2'b01;
  localparam logic [1:0] S_ADR = 2'b10;
  localparam logic [1:0] S_INS = 2'b11;

  // Contents survive reset; only the power-on image is zero.
  logic [7:0]    r_mem [MEM_BYTES] = '{default: 8'h00};

  logic          w_rd;
  logic          w_wr;
  logic [63:0]   w_addr;
  logic [63:0]   w_wdata;
  logic [64:0]   w_end;
  logic          w_dmem_err;
  logic [AW-1:0] w_base;
  logic [63:0]   w_rdata;
  logic [1:0]    w_stat;
  logic          w_we;

  always_comb begin
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (icode)
      I_RMMOVQ: begin w_wr = 1'b1; w_addr = valE; w_wdata = valA; end
      I_MRMOVQ: begin w_rd = 1'b1; w_addr = valE; end
      I_CALL:   begin w_wr = 1'b1; w_addr = valE; w_wdata = valP; end
      I_RET:    begin w_rd = 1'b1; w_addr = valA; end
      I_PUSHQ:  begin w_wr = 1'b1; w_addr = valE; w_wdata = valA; end
      I_POPQ:   begin w_rd = 1'b1; w_addr = valA; end
      default:  ;
    endcase
  end

  // One extra bit so an address near 2^64 wraps into an error rather than a low address.
  assign w_end      = {1'b0, w_addr} + 65'(WORD_BYTES - 1);
  assign w_dmem_err = (w_rd || w_wr) && (w_end >= 65'(MEM_BYTES));
  assign w_base     = w_addr[AW-1:0];

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      w_rdata[8*k +: 8] = r_mem[w_base + AW'(k)];
    end
  end

  always_comb begin
    if (imem_error || w_dmem_err) w_stat = S_ADR;
    else if (!instr_valid)        w_stat = S_INS;
    else if (icode == I_HALT)     w_stat = S_HLT;
    else                          w_stat = S_AOK;
  end

  assign stat = rst ? S_AOK : w_stat;
  assign valM = (rst || !w_rd || w_dmem_err) ? 64'd0 : w_rdata;
  assign w_we = w_wr && !w_dmem_err && (w_stat == S_AOK);

  always_ff @(posedge clk) begin
    if (!rst && w_we) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        r_mem[w_base + AW'(k)] <= w_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_wrap.sv
// Bench for data_wrap: directed steps then random traffic, each checked against a
// byte-array reference memory and status rules evaluated in plain procedural code.
module tb_data_wrap;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        instr_valid, imem_error;
  logic [63:0] valM;
  logic [1:0]  stat;

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned mdl [0:65535];

  data_wrap dut (
    .clk(clk), .rst(rst), .icode(icode), .valE(valE), .valA(valA), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error), .valM(valM), .stat(stat)
  );

  always #5 clk = ~clk;

  function automatic bit is_rd(input logic [3:0] ic);
    return (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
  endfunction

  function automatic bit is_wr(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
  endfunction

  function automatic logic [63:0] m_addr(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a);
    return (ic == 4'h9 || ic == 4'hB) ? a : e;
  endfunction

  function automatic bit m_err(input logic [3:0] ic, input logic [63:0] ad);
    if (!(is_rd(ic) || is_wr(ic))) return 1'b0;
    return ad > 64'd65528;
  endfunction

  function automatic logic [1:0] m_stat(input bit r, input logic [3:0] ic, input logic [63:0] ad,
                                        input bit iv, input bit ie);
    if (r) return 2'b00;
    if (ie || m_err(ic, ad)) return 2'b10;
    if (!iv) return 2'b11;
    if (ic == 4'h0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [63:0] m_word(input logic [63:0] ad);
    logic [63:0] w = '0;
    for (int k = 7; k >= 0; k--) w = (w << 8) | 64'(mdl[int'(ad) + k]);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then clock and update the model.
  task automatic step(input string tag, input bit r, input logic [3:0] ic, input logic [63:0] e,
                      input logic [63:0] a, input logic [63:0] p, input bit iv, input bit ie);
    logic [63:0] ad, exp_m, wd;
    logic [1:0]  exp_s;
    rst = r; icode = ic; valE = e; valA = a; valP = p; instr_valid = iv; imem_error = ie;
    #2;
    ad    = m_addr(ic, e, a);
    exp_s = m_stat(r, ic, ad, iv, ie);
    exp_m = (!r && is_rd(ic) && !m_err(ic, ad)) ? m_word(ad) : 64'd0;
    chk({tag, ".valM"}, valM, exp_m);
    chk({tag, ".stat"}, 64'(stat), 64'(exp_s));
    @(posedge clk);
    if (!r && is_wr(ic) && !m_err(ic, ad) && exp_s == 2'b00) begin
      wd = (ic == 4'h8) ? p : a;
      for (int k = 0; k < 8; k++) mdl[int'(ad) + k] = wd[8*k +: 8];
    end
    #1;
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 64'($urandom_range(0, 63));
      1: return 64'($urandom_range(40, 120));
      2: return 64'($urandom_range(65500, 65545));
      3: return {$urandom, $urandom};
      default: return 64'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) mdl[i] = 8'h00;
    rst = 1'b1; icode = 4'h1; valE = '0; valA = '0; valP = '0; instr_valid = 1'b1; imem_error = 1'b0;
    @(posedge clk); #1;

    // reset: outputs quiet and write suppressed
    step("rst_wr", 1, 4'h4, 64'd200, 64'hDEAD_BEEF, 0, 1, 0);
    step("rst_rd", 0, 4'h5, 64'd200, 0, 0, 1, 0);
    chk("rst_no_write", valM, 64'd0);

    step("t1_adr", 0, 4'h4, 64'd65536, 64'd12, 0, 1, 0);
    chk("t1_stat", 64'(stat), 64'd2);
    step("t2_rd0", 0, 4'h5, 64'd58, 0, 0, 1, 0);

    step("t3_wr", 0, 4'h4, 64'd58, 64'd12, 0, 1, 0);
    step("t3_mr", 0, 4'h5, 64'd58, 0, 0, 1, 0);
    chk("t3_mr_const", valM, 64'd12);
    step("t3_ret", 0, 4'h9, 0, 64'd58, 0, 1, 0);
    chk("t3_ret_const", valM, 64'd12);

    step("t4_call", 0, 4'h8, 64'd100, 64'd999, 64'd11, 1, 0);
    step("t4_pop", 0, 4'hB, 64'd777, 64'd100, 0, 1, 0);
    chk("t4_pop_const", valM, 64'd11);
    step("t4_bytes", 0, 4'h5, 64'd93, 0, 0, 1, 0);
    chk("t4_byte100", valM, 64'h0B00_0000_0000_0000);
    step("t4_hi", 0, 4'h5, 64'd101, 0, 0, 1, 0);
    chk("t4_byte101_107", valM, 64'd0);

    step("t5_wr_top", 0, 4'h4, 64'd65528, 64'h0102_0304_0506_0708, 0, 1, 0);
    step("t5_rd_top", 0, 4'h5, 64'd65528, 0, 0, 1, 0);
    chk("t5_top_word", valM, 64'h0102_0304_0506_0708);
    step("t5_wr_over", 0, 4'h4, 64'd65529, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
    step("t5_rd_after", 0, 4'h5, 64'd65528, 0, 0, 1, 0);
    step("t5_wrap", 0, 4'hB, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0);

    step("t6_ins", 0, 4'h4, 64'd300, 64'h55, 0, 0, 0);
    step("t6_adr", 0, 4'h4, 64'd300, 64'h66, 0, 0, 1);
    step("t6_hlt", 0, 4'h0, 0, 0, 0, 1, 0);
    step("t6_rst_wr", 1, 4'hA, 64'd58, 64'hAAAA, 0, 1, 0);
    step("t6_chk", 0, 4'h5, 64'd300, 0, 0, 1, 0);
    step("t6_chk58", 0, 4'h5, 64'd58, 0, 0, 1, 0);
    chk("t6_rst_no_write", valM, 64'd12);

    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), rand_addr(), rand_addr(),
           {$urandom, $urandom}, ($urandom_range(0, 9) != 0), ($urandom_range(0, 14) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
